// File: rtl/seg_scan_controller.sv
// Refresh scheduler for a multiplexed 7-segment display behind a 16-bit shift/latch chain.
// Define SEG_ACTIVE_LOW_EN to invert both frame bytes for common-anode / PNP drivers.
module seg_scan_controller #(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_DIV     = 4,
  parameter int REFRESH_GAP = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       ser_data,
  output logic       ser_clk,
  output logic       ser_latch,
  output logic       busy,
  output logic [2:0] digit_idx,
  output logic       frame_done
);

  localparam int CMAX  = (CLK_DIV > REFRESH_GAP) ? CLK_DIV : REFRESH_GAP;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_PEN  = CNT_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(REFRESH_GAP - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]       SEL_MASK = 8'((1 << NUM_DIGITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_LATCH, S_GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bitcnt;
  logic [15:0]      shreg;
  logic [15:0]      frame;
  logic [7:0]       digits [8];

  function automatic logic [15:0] build_frame(input logic [2:0] idx, input logic [7:0] seg);
    logic [15:0] f;
    f = {(8'h01 << idx) & SEL_MASK, seg};
`ifdef SEG_ACTIVE_LOW_EN
    f = ~f;
`endif
    return f;
  endfunction

  assign frame = build_frame(digit_idx, digits[digit_idx]);

  // Digit storage keeps the uninverted pattern; out-of-range addresses are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) digits[i] <= 8'h00;
    end else if (wr_en && ({1'b0, wr_addr} < 4'(NUM_DIGITS))) begin
      digits[wr_addr] <= wr_data;
    end
  end

  // Frame snapshot taken at LOAD so later writes only affect the next frame.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) shreg <= frame;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bitcnt     <= 4'd0;
      ser_data   <= 1'b0;
      ser_clk    <= 1'b0;
      ser_latch  <= 1'b0;
      busy       <= 1'b0;
      digit_idx  <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          bitcnt   <= 4'd15;
          ser_data <= frame[15];
          cnt      <= '0;
          state    <= S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            ser_clk <= 1'b1;
            state   <= S_SHIFT_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT_HI: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            ser_clk <= 1'b0;
            if (bitcnt == 4'd0) begin
              ser_data   <= 1'b0;
              ser_latch  <= 1'b1;
              frame_done <= (CLK_DIV == 1);
              state      <= S_LATCH;
            end else begin
              bitcnt   <= bitcnt - 4'd1;
              ser_data <= shreg[bitcnt - 4'd1];
              state    <= S_SHIFT_LO;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LATCH: begin
          // frame_done is raised one cycle early so it lines up with the final latch cycle.
          if (cnt == DIV_LAST) begin
            cnt       <= '0;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
            digit_idx <= (digit_idx == IDX_LAST) ? 3'd0 : digit_idx + 3'd1;
            state     <= S_GAP;
          end else begin
            cnt        <= cnt + 1'b1;
            frame_done <= (cnt == DIV_PEN);
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (enable) begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Refresh scheduler for a multiplexed 7-segment display driven through a 16-bit serial shift/latch register chain.
- Holds one segment pattern per digit and builds a 16-bit frame for one digit at a time: select byte in the high byte, segment byte in the low byte.
- Shifts each frame out MSB-first with a divided serial clock, pulses the latch, waits a refresh gap, then advances to the next digit.
- Sits between the user logic (write port) and the off-chip shift-register pins.

Parameters:
- NUM_DIGITS, default 8: number of digits scanned. Legal range 1..8.
- CLK_DIV, default 4: clk cycles per ser_clk half-period, and the latch pulse width. Must be >=1.
- REFRESH_GAP, default 1000: idle clk cycles after each latch before the next frame. Must be >=1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  scanning enable.
- wr_en  input  1  digit register write strobe.
- wr_addr  input  3  digit index to write.
- wr_data  input  8  segment pattern; bit0=a .. bit6=g, bit7=dp.
- ser_data  output  1  serial data to the shift-register chain.
- ser_clk  output  1  shift clock; the chain samples on its rising edge.
- ser_latch  output  1  storage-register latch pulse, active high.
- busy  output  1  high from LOAD through LATCH.
- digit_idx  output  3  digit currently or next being sent.
- frame_done  output  1  one-cycle pulse at the end of LATCH.

Behaviour:
- Reset (async):
  - Digit registers cleared to 0x00; digit_idx=0; state IDLE.
  - ser_data, ser_clk, ser_latch, busy and frame_done all 0 immediately.
  - Reset mid-frame aborts with no latch pulse, so the external display keeps its previous pattern.
- Writes:
  - Accepted every cycle in any state when wr_en=1 and wr_addr<NUM_DIGITS; addresses >=NUM_DIGITS are ignored.
  - The frame is snapshotted at LOAD. A write to the digit in flight takes effect on that digit's next frame.
- Frame contents: frame[15:8] = one-hot select, bit digit_idx=1, all bits >=NUM_DIGITS=0. frame[7:0] = digit register[digit_idx].
- State machine:
  - IDLE: all outputs 0. enable=1 -> LOAD on the next cycle.
  - LOAD (1 cycle): shift register <= frame; bit counter <= 15; ser_data <= frame[15]; -> SHIFT_LO.
  - SHIFT_LO: ser_clk=0 for CLK_DIV cycles -> SHIFT_HI.
  - SHIFT_HI: ser_clk=1 for CLK_DIV cycles. On exit:
    - bit counter==0 -> LATCH, ser_data <= 0.
    - otherwise decrement the counter, present the next lower bit on ser_data, -> SHIFT_LO.
  - LATCH: ser_latch=1 for CLK_DIV cycles. On the last cycle, frame_done=1 for one cycle, and digit_idx advances; at NUM_DIGITS-1 it wraps to 0. -> GAP.
  - GAP: REFRESH_GAP cycles, then enable=1 -> LOAD, enable=0 -> IDLE.
- ser_data is stable for the full ser_clk low and high phases, so setup and hold each equal CLK_DIV clk cycles.
- Frame period (LOAD to next LOAD) = 1 + 32*CLK_DIV + CLK_DIV + REFRESH_GAP cycles; 1133 at defaults.
- enable deasserted mid-frame: the frame still completes, including latch, frame_done and index advance, then GAP, then IDLE. digit_idx is held in IDLE.
- NUM_DIGITS=1: digit_idx stays 0 and the select byte is 0x01 every frame.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SEG_ACTIVE_LOW_EN.
- Defined: both frame bytes are bit-inverted before shifting (common-anode / PNP drivers). Select is one-cold, segments are active low.
- Undefined: bytes are sent as described above.
- Either way, idle/reset levels of ser_data, ser_clk and ser_latch stay 0, and the digit registers store the uninverted wr_data.

Test Plan:
- Basic frame, NUM_DIGITS=4, CLK_DIV=2, REFRESH_GAP=10: reset, write addr0=0xA5, enable=1.
  - ser_data sampled on 16 ser_clk rises = 0x01A5, MSB first.
  - One ser_latch pulse 2 cycles wide, then frame_done; next LOAD 77 cycles after the first.
- Scan wrap: write 0x11,0x22,0x33,0x44 to addrs 0..3, run 5 frames.
  - Frames 0x0111, 0x0222, 0x0433, 0x0844, 0x0111; digit_idx sequence 0,1,2,3,0.
- Mid-frame write: during digit0's shift, write addr0=0xFF.
  - Current frame is still 0x01A5; digit0's next frame is 0x01FF. Write to addr 5 is ignored, with no frame change.
- Enable drop: deassert enable during SHIFT_HI of bit 7.
  - Frame completes with latch and frame_done, digit_idx becomes 1, state reaches IDLE after 10 gap cycles.
  - No further ser_clk edges.
- Reset mid-frame: assert rst after 5 ser_clk rises.
  - All outputs 0 in the same cycle; no ser_latch pulse.
  - Registers read as 0x00, giving a next frame of 0x0100 after re-enable.
- With SEG_ACTIVE_LOW_EN: repeat the basic frame scenario; shifted word = 0xFE5A, ser_latch still active high.
